search_chain_walker: RTL and testbench
======================================

SEARCH_CHAIN_WALKER -- requirements
Module: search_chain_walker

Interface
REQ-001 Params SHALL be: IDX_W, default 11, table index width; RULE_W, default 11, rule ID width; MAX_HOPS, default 16, chain-walk limit; FIRST_MATCH, default 0, 1 = stop at first hit, 0 = walk full chain and keep best.
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 req_valid  in  1; req_ready  out  1; req_index  in  IDX_W  chain head; req_tuple  in  104  {proto[103:96], dstPort[95:80], srcPort[79:64], dstIP[63:32], srcIP[31:0]}.
REQ-004 mem_en  out  1; mem_addr  out  IDX_W; mem_rdata  in  ENTRY_W = 149+RULE_W+IDX_W  entry, valid the cycle after mem_en.
REQ-005 resp_valid  out  1; resp_ready  in  1; resp_match  out  1; resp_ruleID  out  RULE_W; resp_hops  out  $clog2(MAX_HOPS+1); resp_overflow  out  1.

Function
REQ-006 Entry layout SHALL be: srcIP[31:0], srcLen[37:32], dstIP[69:38], dstLen[75:70], srcPortHi[91:76], srcPortLo[107:92], dstPortHi[123:108], dstPortLo[139:124], proto[147:140], protoWild[148], ruleID[148+RULE_W:149], next[ENTRY_W-1:149+RULE_W].
REQ-007 Hit SHALL require: srcIP match on top srcLen bits (len 0 = wildcard, >32 treated as 32); same for dstIP/dstLen; srcPortLo<=srcPort<=srcPortHi; dstPortLo<=dstPort<=dstPortHi; protoWild or proto equal.
REQ-008 Index 0 SHALL be the null pointer; entry 0 is never fetched.
REQ-009 FSM SHALL have states IDLE, FETCH, EVAL, RESP.
REQ-010 IDLE: req_ready=1; on req_valid, latch tuple and req_index, clear best/hops/overflow; go FETCH, or RESP directly if req_index==0.
REQ-011 FETCH: mem_en=1, mem_addr=current index, one cycle; go EVAL.
REQ-012 EVAL: compare mem_rdata, increment hops; on hit with no prior hit or ruleID < best, store best (lowest ruleID wins, ties keep earlier).
REQ-013 EVAL exit: RESP if (FIRST_MATCH and hit) or next==0 or hops==MAX_HOPS; else index<=next, go FETCH.
REQ-014 hops==MAX_HOPS with next!=0 SHALL set resp_overflow=1; result still carries best so far.
REQ-015 RESP: resp_valid=1, outputs stable until resp_ready; on resp_valid&&resp_ready return IDLE; req_ready=0 outside IDLE.
REQ-016 Latency: request accepted in cycle T, N hops -> resp_valid first high in cycle T+2N+1; N=0 -> T+1.
REQ-017 mem_en SHALL be 0 in all states except FETCH; mem_addr don't-care when mem_en=0.
REQ-018 A new request SHALL NOT be accepted in the cycle a response is consumed.

Reset
REQ-019 rst_n low at clk edge SHALL force IDLE, resp_valid=0, resp_match=0, resp_ruleID=0, resp_hops=0, resp_overflow=0, mem_en=0; req_ready=1 from the first cycle after release.
REQ-020 Reset mid-walk SHALL abandon the walk with no response produced.

Structure
REQ-021 Package search_pkg SHALL hold entry field offsets/widths, tuple field offsets, null-index constant, and FSM state enum.
REQ-022 The per-entry compare SHALL be one combinational sub-module search_entry_match (entry, tuple -> hit, ruleID, next).

Verification
REQ-023 Head 5 -> entry 5 exact match ruleID 7, next 0: resp_match=1, ruleID=7, hops=1, resp_valid at T+3.
REQ-024 Chain 3->9->4, hits at 9 (rule 20) and 4 (rule 12), FIRST_MATCH=0: ruleID=12, hops=3; FIRST_MATCH=1: ruleID=20, hops=2.
REQ-025 req_index=0: resp_match=0, hops=0, resp_valid at T+1, mem_en never asserted.
REQ-026 20-entry cyclic chain, MAX_HOPS=16, no hits: resp_overflow=1, hops=16, match=0.
REQ-027 Boundaries: srcPort equal to Lo and to Hi hit, Hi+1 misses; srcLen=0 wildcards; protoWild=1 with mismatched proto hits.
REQ-028 resp_ready held low 5 cycles: outputs stable, req_ready=0; rst_n low during EVAL: IDLE next cycle, no resp_valid.

Source files
------------

// File: rtl/search_chain_walker_pkg.sv
// search_pkg: shared constants and types for the search chain walker.
//   - Rule entry field offsets/widths (ruleID/next offsets depend on the
//     RULE_W/IDX_W parameters and are derived in the modules).
//   - Lookup tuple field offsets.
//   - Null chain index constant.
//   - Walker FSM state enum.
//   - prefix_match(): masked IP compare on the top 'len' bits.
package search_pkg;

    // Entry layout (LSB offsets)
    localparam int unsigned IP_W       = 32;
    localparam int unsigned LEN_W      = 6;
    localparam int unsigned PORT_W     = 16;
    localparam int unsigned PROTO_W    = 8;
    localparam int unsigned E_SIP_LSB  = 0;
    localparam int unsigned E_SLEN_LSB = 32;
    localparam int unsigned E_DIP_LSB  = 38;
    localparam int unsigned E_DLEN_LSB = 70;
    localparam int unsigned E_SPHI_LSB = 76;
    localparam int unsigned E_SPLO_LSB = 92;
    localparam int unsigned E_DPHI_LSB = 108;
    localparam int unsigned E_DPLO_LSB = 124;
    localparam int unsigned E_PROTO_LSB = 140;
    localparam int unsigned E_PWILD_BIT = 148;
    localparam int unsigned E_RULE_LSB  = 149;

    // Tuple layout {proto, dstPort, srcPort, dstIP, srcIP}
    localparam int unsigned TUPLE_W      = 104;
    localparam int unsigned T_SIP_LSB    = 0;
    localparam int unsigned T_DIP_LSB    = 32;
    localparam int unsigned T_SPORT_LSB  = 64;
    localparam int unsigned T_DPORT_LSB  = 80;
    localparam int unsigned T_PROTO_LSB  = 96;

    // Index 0 terminates a chain and is never fetched
    localparam int unsigned NULL_IDX = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        RESP
    } state_t;

    // Prefix lengths above 32 saturate to 32; a length of 0 shifts the
    // mask fully out, making the field a wildcard.
    function automatic logic prefix_match(input logic [IP_W-1:0]  a,
                                          input logic [IP_W-1:0]  b,
                                          input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] l;
        logic [IP_W-1:0]  mask;
        l    = (len > 6'd32) ? 6'd32 : len;
        mask = 32'hFFFF_FFFF << (6'd32 - l);
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/search_chain_walker_entry_match.sv
// search_entry_match: combinational compare of one rule entry against a
// lookup tuple.
// Ports:
//   i_entry   - rule entry (fields per search_pkg offsets)
//   i_tuple   - lookup 5-tuple
//   o_hit     - entry matches tuple
//   o_rule_id - entry ruleID field
//   o_next    - entry next-pointer field
module search_entry_match
    import search_pkg::*;
#(
    parameter int unsigned IDX_W  = 11,
    parameter int unsigned RULE_W = 11,
    localparam int unsigned ENTRY_W = 149 + RULE_W + IDX_W
) (
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic [TUPLE_W-1:0] i_tuple,
    output logic               o_hit,
    output logic [RULE_W-1:0]  o_rule_id,
    output logic [IDX_W-1:0]   o_next
);

    logic w_sip_ok;
    logic w_dip_ok;
    logic w_sport_ok;
    logic w_dport_ok;
    logic w_proto_ok;

    logic [PORT_W-1:0] w_sport;
    logic [PORT_W-1:0] w_dport;

    assign w_sport = i_tuple[T_SPORT_LSB +: PORT_W];
    assign w_dport = i_tuple[T_DPORT_LSB +: PORT_W];

    assign w_sip_ok = prefix_match(i_entry[E_SIP_LSB +: IP_W],
                                   i_tuple[T_SIP_LSB +: IP_W],
                                   i_entry[E_SLEN_LSB +: LEN_W]);
    assign w_dip_ok = prefix_match(i_entry[E_DIP_LSB +: IP_W],
                                   i_tuple[T_DIP_LSB +: IP_W],
                                   i_entry[E_DLEN_LSB +: LEN_W]);

    assign w_sport_ok = (w_sport >= i_entry[E_SPLO_LSB +: PORT_W]) &&
                        (w_sport <= i_entry[E_SPHI_LSB +: PORT_W]);
    assign w_dport_ok = (w_dport >= i_entry[E_DPLO_LSB +: PORT_W]) &&
                        (w_dport <= i_entry[E_DPHI_LSB +: PORT_W]);

    assign w_proto_ok = i_entry[E_PWILD_BIT] ||
                        (i_entry[E_PROTO_LSB +: PROTO_W] == i_tuple[T_PROTO_LSB +: PROTO_W]);

    assign o_hit     = w_sip_ok && w_dip_ok && w_sport_ok && w_dport_ok && w_proto_ok;
    assign o_rule_id = i_entry[E_RULE_LSB +: RULE_W];
    assign o_next    = i_entry[E_RULE_LSB + RULE_W +: IDX_W];

endmodule

// File: rtl/search_chain_walker.sv
// search_chain_walker: walks a linked chain of rule entries in an external
// synchronous memory, returning the lowest matching ruleID (or the first
// hit when FIRST_MATCH=1).
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   req_valid/req_ready    - request handshake; req_index = chain head,
//                            req_tuple = {proto,dstPort,srcPort,dstIP,srcIP}
//   mem_en/mem_addr        - entry read; mem_rdata valid the cycle after
//   resp_valid/resp_ready  - response handshake
//   resp_match/ruleID      - best hit found (ruleID 0 when no hit)
//   resp_hops              - entries examined
//   resp_overflow          - walk cut off at MAX_HOPS with chain remaining
module search_chain_walker
    import search_pkg::*;
#(
    parameter int unsigned IDX_W       = 11,
    parameter int unsigned RULE_W      = 11,
    parameter int unsigned MAX_HOPS    = 16,
    parameter int unsigned FIRST_MATCH = 0,
    localparam int unsigned ENTRY_W = 149 + RULE_W + IDX_W,
    localparam int unsigned HOPS_W  = $clog2(MAX_HOPS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_index,
    input  logic [TUPLE_W-1:0]  req_tuple,
    output logic                mem_en,
    output logic [IDX_W-1:0]    mem_addr,
    input  logic [ENTRY_W-1:0]  mem_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_match,
    output logic [RULE_W-1:0]   resp_ruleID,
    output logic [HOPS_W-1:0]   resp_hops,
    output logic                resp_overflow
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_index;
    logic [TUPLE_W-1:0]  r_tuple;
    logic                r_best_valid;
    logic [RULE_W-1:0]   r_best_rule;
    logic [HOPS_W-1:0]   r_hops;
    logic                r_overflow;

    logic                w_hit;
    logic [RULE_W-1:0]   w_rule;
    logic [IDX_W-1:0]    w_next;
    logic [HOPS_W-1:0]   w_hops_inc;
    logic                w_at_limit;
    logic                w_next_null;
    logic                w_stop;
    logic                w_take;

    search_entry_match #(
        .IDX_W  (IDX_W),
        .RULE_W (RULE_W)
    ) u_match (
        .i_entry   (mem_rdata),
        .i_tuple   (r_tuple),
        .o_hit     (w_hit),
        .o_rule_id (w_rule),
        .o_next    (w_next)
    );

    assign w_hops_inc  = r_hops + HOPS_W'(1);
    assign w_at_limit  = (w_hops_inc == HOPS_W'(MAX_HOPS));
    assign w_next_null = (w_next == IDX_W'(NULL_IDX));
    assign w_stop      = ((FIRST_MATCH != 0) && w_hit) || w_next_null || w_at_limit;
    // Strict less-than: on equal ruleIDs the earlier entry is kept
    assign w_take      = w_hit && (!r_best_valid || (w_rule < r_best_rule));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_en      = 1'b0;
        resp_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_nxt = (req_index == IDX_W'(NULL_IDX)) ? RESP : FETCH;
            end
            FETCH: begin
                mem_en      = 1'b1;
                w_state_nxt = EVAL;
            end
            EVAL: begin
                w_state_nxt = w_stop ? RESP : FETCH;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_index      <= '0;
            r_tuple      <= '0;
            r_best_valid <= 1'b0;
            r_best_rule  <= '0;
            r_hops       <= '0;
            r_overflow   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_index      <= req_index;
                        r_tuple      <= req_tuple;
                        r_best_valid <= 1'b0;
                        r_best_rule  <= '0;
                        r_hops       <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                EVAL: begin
                    r_hops     <= w_hops_inc;
                    r_overflow <= w_at_limit && !w_next_null;
                    if (w_take) begin
                        r_best_valid <= 1'b1;
                        r_best_rule  <= w_rule;
                    end
                    if (!w_stop) r_index <= w_next;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr      = r_index;
    assign resp_match    = r_best_valid;
    assign resp_ruleID   = r_best_rule;
    assign resp_hops     = r_hops;
    assign resp_overflow = r_overflow;

endmodule

// File: tb/tb_search_chain_walker.sv
// Scoreboard bench for search_chain_walker: two instances (FIRST_MATCH 0/1)
// share one entry memory image; each has its own registered read port.
module tb_search_chain_walker;

    localparam int IDX_W  = 11;
    localparam int RULE_W = 11;
    localparam int EW     = 149 + RULE_W + IDX_W;
    localparam int HW     = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              req_valid     [2];
    logic              req_ready     [2];
    logic [IDX_W-1:0]  req_index     [2];
    logic [103:0]      req_tuple     [2];
    logic              mem_en        [2];
    logic [IDX_W-1:0]  mem_addr      [2];
    logic [EW-1:0]     mem_rdata     [2];
    logic              resp_valid    [2];
    logic              resp_ready    [2];
    logic              resp_match    [2];
    logic [RULE_W-1:0] resp_ruleID   [2];
    logic [HW-1:0]     resp_hops     [2];
    logic              resp_overflow [2];

    search_chain_walker #(.IDX_W(IDX_W), .RULE_W(RULE_W), .MAX_HOPS(16), .FIRST_MATCH(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_index(req_index[0]), .req_tuple(req_tuple[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_match(resp_match[0]), .resp_ruleID(resp_ruleID[0]),
        .resp_hops(resp_hops[0]), .resp_overflow(resp_overflow[0])
    );

    search_chain_walker #(.IDX_W(IDX_W), .RULE_W(RULE_W), .MAX_HOPS(16), .FIRST_MATCH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_index(req_index[1]), .req_tuple(req_tuple[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_match(resp_match[1]), .resp_ruleID(resp_ruleID[1]),
        .resp_hops(resp_hops[1]), .resp_overflow(resp_overflow[1])
    );

    logic [EW-1:0] mem [2048];
    int en_cnt0   = 0;
    int zero_addr = 0;

    always @(posedge clk) if (mem_en[0]) mem_rdata[0] <= mem[mem_addr[0]];
    always @(posedge clk) if (mem_en[1]) mem_rdata[1] <= mem[mem_addr[1]];
    always @(posedge clk) begin
        if (mem_en[0]) en_cnt0 <= en_cnt0 + 1;
        if ((mem_en[0] && mem_addr[0] == '0) || (mem_en[1] && mem_addr[1] == '0))
            zero_addr <= zero_addr + 1;
    end

    typedef struct {
        logic              match;
        logic [RULE_W-1:0] rule;
        logic [HW-1:0]     hops;
        logic              ovf;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [31:0] sip, input logic [5:0] sl,
                                         input logic [31:0] dip, input logic [5:0] dl,
                                         input logic [15:0] splo, input logic [15:0] sphi,
                                         input logic [15:0] dplo, input logic [15:0] dphi,
                                         input logic [7:0] pr, input logic pw,
                                         input logic [10:0] rule, input logic [10:0] nxt);
        return {nxt, rule, pw, pr, dplo, dphi, splo, sphi, dl, dip, sl, sip};
    endfunction

    function automatic logic [103:0] tup(input logic [31:0] sip, input logic [31:0] dip,
                                         input logic [15:0] sp, input logic [15:0] dp,
                                         input logic [7:0] pr);
        return {pr, dp, sp, dip, sip};
    endfunction

    localparam logic [31:0] SIP = 32'h0A00_0001;
    localparam logic [31:0] DIP = 32'hC0A8_0105;

    function automatic logic [EW-1:0] exact(input logic [10:0] rule, input logic [10:0] nxt);
        return mk(SIP, 6'd32, DIP, 6'd32, 16'd1234, 16'd1234, 16'd80, 16'd80, 8'd6, 1'b0, rule, nxt);
    endfunction

    function automatic logic [EW-1:0] miss(input logic [10:0] nxt);
        return mk(SIP, 6'd32, DIP, 6'd32, 16'd1234, 16'd1234, 16'd80, 16'd80, 8'd17, 1'b0, 11'd99, nxt);
    endfunction

    // Drive one request and wait (bounded) for the accepting edge.
    task automatic send(input int sel, input logic [IDX_W-1:0] idx, input logic [103:0] t);
        int w;
        req_index[sel] = idx;
        req_tuple[sel] = t;
        req_valid[sel] = 1'b1;
        w = 0;
        while (!req_ready[sel] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready[sel]) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
    endtask

    task automatic push(input logic m, input logic [10:0] r, input logic [HW-1:0] h, input logic o);
        exp_t e;
        e.match = m; e.rule = r; e.hops = h; e.ovf = o;
        sb.push_back(e);
    endtask

    // Called just after the accepting edge; d counts cycles since accept.
    task automatic collect(input int sel, input int hold);
        exp_t e;
        int d;
        d = 1;
        while (!resp_valid[sel] && d < 200) begin
            @(posedge clk); #1; d++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("resp_valid", resp_valid[sel], 1);
        check("latency",    d, 2 * e.hops + 1);
        check("match",      resp_match[sel], e.match);
        check("ruleID",     resp_ruleID[sel], e.rule);
        check("hops",       resp_hops[sel], e.hops);
        check("overflow",   resp_overflow[sel], e.ovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid",  resp_valid[sel], 1);
            check("hold_rule",   resp_ruleID[sel], e.rule);
            check("hold_hops",   resp_hops[sel], e.hops);
            check("hold_match",  resp_match[sel], e.match);
            check("hold_rready", req_ready[sel], 0);
        end
        resp_ready[sel] = 1'b1;
        @(posedge clk); #1;
        check("post_valid", resp_valid[sel], 0);
        check("post_ready", req_ready[sel], 1);
    endtask

    task automatic run(input int sel, input logic [IDX_W-1:0] idx, input logic [103:0] t,
                       input logic m, input logic [10:0] r, input logic [HW-1:0] h, input logic o);
        push(m, r, h, o);
        send(sel, idx, t);
        collect(sel, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] t0;
        int en_before;
        int seen;

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[5]  = exact(11'd7, 11'd0);
        mem[3]  = miss(11'd9);
        mem[9]  = exact(11'd20, 11'd4);
        mem[4]  = exact(11'd12, 11'd0);
        mem[50] = exact(11'd5, 11'd51);
        mem[51] = exact(11'd8, 11'd0);
        for (int i = 0; i < 20; i++) mem[100 + i] = miss(11'(100 + ((i + 1) % 20)));
        mem[30] = mk(32'h1234_5678, 6'd0, DIP & 32'hFFFF_FF00, 6'd24, 16'd1000, 16'd2000,
                     16'd0, 16'hFFFF, 8'd6, 1'b0, 11'd50, 11'd0);
        mem[31] = mk(SIP, 6'd32, DIP, 6'd32, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd17, 1'b1, 11'd60, 11'd0);
        mem[32] = mk(SIP, 6'd40, DIP, 6'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd6, 1'b0, 11'd70, 11'd0);

        t0 = tup(SIP, DIP, 16'd1234, 16'd80, 8'd6);
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_index[s] = '0; req_tuple[s] = '0; resp_ready[s] = 1'b1;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", resp_valid[0], 0);
        check("rst_match", resp_match[0], 0);
        check("rst_rule",  resp_ruleID[0], 0);
        check("rst_hops",  resp_hops[0], 0);
        check("rst_ovf",   resp_overflow[0], 0);
        check("rst_mem_en", mem_en[0], 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready[0], 1);

        // Single exact hit
        run(0, 11'd5, t0, 1'b1, 11'd7, 5'd1, 1'b0);

        // Chain 3->9->4: lowest rule vs first hit
        run(0, 11'd3, t0, 1'b1, 11'd12, 5'd3, 1'b0);
        run(1, 11'd3, t0, 1'b1, 11'd20, 5'd2, 1'b0);
        // Lower rule first must not be replaced by a later higher one
        run(0, 11'd50, t0, 1'b1, 11'd5, 5'd2, 1'b0);

        // Null head
        en_before = en_cnt0;
        run(0, 11'd0, t0, 1'b0, 11'd0, 5'd0, 1'b0);
        check("null_no_fetch", en_cnt0 - en_before, 0);

        // Cyclic chain overflow
        run(0, 11'd100, t0, 1'b0, 11'd0, 5'd16, 1'b1);

        // Port/prefix/proto boundaries
        run(0, 11'd30, tup(SIP, DIP, 16'd1000, 16'd80, 8'd6), 1'b1, 11'd50, 5'd1, 1'b0);
        run(0, 11'd30, tup(SIP, DIP, 16'd2000, 16'd80, 8'd6), 1'b1, 11'd50, 5'd1, 1'b0);
        run(0, 11'd30, tup(SIP, DIP, 16'd2001, 16'd80, 8'd6), 1'b0, 11'd0, 5'd1, 1'b0);
        run(0, 11'd30, tup(SIP, DIP, 16'd999,  16'd80, 8'd6), 1'b0, 11'd0, 5'd1, 1'b0);
        run(0, 11'd30, tup(SIP, DIP ^ 32'h80, 16'd1500, 16'd80, 8'd6), 1'b1, 11'd50, 5'd1, 1'b0);
        run(0, 11'd30, tup(SIP, DIP ^ 32'h100, 16'd1500, 16'd80, 8'd6), 1'b0, 11'd0, 5'd1, 1'b0);
        run(0, 11'd31, t0, 1'b1, 11'd60, 5'd1, 1'b0);
        run(0, 11'd32, t0, 1'b1, 11'd70, 5'd1, 1'b0);
        run(0, 11'd32, tup(SIP ^ 32'h1, DIP, 16'd1234, 16'd80, 8'd6), 1'b0, 11'd0, 5'd1, 1'b0);

        // Backpressure: hold resp_ready low 5 cycles
        resp_ready[0] = 1'b0;
        push(1'b1, 11'd12, 5'd3, 1'b0);
        send(0, 11'd3, t0);
        collect(0, 5);

        // Reset during EVAL abandons the walk
        send(0, 11'd3, t0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready",  req_ready[0], 1);
        check("midrst_valid",  resp_valid[0], 0);
        check("midrst_mem_en", mem_en[0], 0);
        check("midrst_hops",   resp_hops[0], 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid[0]) seen++;
        end
        check("midrst_no_resp", seen, 0);

        // Recovery after reset
        run(0, 11'd5, t0, 1'b1, 11'd7, 5'd1, 1'b0);

        check("zero_fetch", zero_addr, 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
